recovery_rf_restore_ctrl: RTL and testbench
===========================================

// Module: recovery_rf_restore_ctrl
// PURPOSE
//  Sequences the rapid-recovery register file (RRF). In normal operation it forwards core
//  writeback traffic (ports A/B) into the RRF as backup writes. On start_i it reads every
//  architectural register out of the RRF, two per beat, and replays them onto the core RF
//  write ports. Core backup writes are blocked while a restore runs. Sits between the core
//  writeback stage, the RRF and the core RF inside the rapid-recovery unit.
// PARAMETERS
//  ADDR_WIDTH  6   register address width; bit 5 selects the FP bank
//  DataWidth   32  architectural register width (ECC handled inside the RRF)
//  FPU         0   1: FP bank present
//  PULP_ZFINX  0   1: FP shares the integer RF (FP bank absent)
//  NumRegs  (local) = (FPU && !PULP_ZFINX) ? 64 : 32; restore covers addresses 1..NumRegs-1
// PORTS
//  clk_i          in   1           clock
//  rst_i          in   1           synchronous, active-high reset
//  start_i        in   1           restore request (sampled in IDLE only)
//  busy_o         out  1           restore in progress
//  done_o         out  1           one-cycle pulse: restore complete
//  backup_en_i    in   1           enables forwarding of core writes to the RRF
//  core_we_a_i    in   1           core writeback port A enable (B identical: *_b_*)
//  core_waddr_a_i in   ADDR_WIDTH  core writeback port A address
//  core_wdata_a_i in   DataWidth   core writeback port A data
//  rf_we_a_o      out  1           RRF write port A enable (B identical)
//  rf_waddr_a_o   out  ADDR_WIDTH  RRF write port A address
//  rf_wdata_a_o   out  DataWidth   RRF write port A data
//  rf_raddr_a_o   out  ADDR_WIDTH  RRF read port A address (B identical)
//  rf_rdata_a_i   in   DataWidth   RRF read port A data, combinational w.r.t. address
//  rst_we_a_o     out  1           core RF restore write A enable (B identical)
//  rst_waddr_a_o  out  ADDR_WIDTH  core RF restore write A address
//  rst_wdata_a_o  out  DataWidth   core RF restore write A data
//  core_ready_i   in   1           core RF accepts restore writes this cycle
// BEHAVIOUR
//  Reset: state=IDLE, cnt=1, out stage invalid; busy_o, done_o, rst_we_* = 0; rf_raddr_* = 0.
//  Backup path: combinational. rf_we_x_o = core_we_x_i & backup_en_i & ~busy_o;
//   address and data pass through unmodified. A write presented in the same cycle as
//   start_i is still forwarded.
//  FSM IDLE -> ISSUE on start_i; cnt=1.
//  ISSUE: rf_raddr_a_o=cnt, rf_raddr_b_o=cnt+1. Capture occurs when the out stage is
//   invalid or core_ready_i=1. On capture, out regs load {addr,data} for A and B;
//   we_b = (cnt+1 <= NumRegs-1); cnt += 2. The capture with cnt+2 > NumRegs-1 is the
//   last beat -> DRAIN.
//  DRAIN: when core_ready_i=1, out stage clears -> DONE.
//  DONE: done_o=1 for exactly one cycle -> IDLE.
//  busy_o=1 in ISSUE, DRAIN and DONE.
//  Out stage: rst_we_* stay high and rst_waddr/wdata stay stable until core_ready_i=1.
//   One handshake is one beat. No address is skipped or repeated.
//  Latency with ready=1: start_i in cycle 0 -> first restore beat in cycle 2; beat n in
//   cycle 2+n; done_o in the cycle after the last handshake.
//   32 regs: 16 beats, done in cycle 18. 64 regs: 32 beats, done in cycle 34.
//  start_i while busy_o=1 is ignored. x0 is never written by a restore.
//  rst_i mid-restore: next cycle state is IDLE and all outputs are 0. No partial beat is
//   completed. A new start_i restarts from address 1.
// TESTING
//  1 Reset, then idle, ready=1 -> busy_o, done_o, rst_we_a/b_o, rf_we_a/b_o all 0.
//  2 backup_en=1, core_we_a=1, waddr 5, data 32'hDEADBEEF -> rf_we_a_o=1, addr 5, same data,
//    same cycle; backup_en=0 -> rf_we_a_o=0.
//  3 FPU=0, ready=1, RRF[r]=r*32'h01010101, start_i in cycle 0 -> writes (1,2)...(29,30)
//    in cycles 2..16; cycle 17 writes addr 31 on A with we_b=0; done_o only in cycle 18.
//  4 As 3 with ready=0 in cycles 5..7 -> beat held stable 3 cycles, no address lost,
//    done_o in cycle 21.
//  5 During busy: start_i pulse and core_we_a=1 -> no restart, rf_we_a_o=0, sequence
//    unchanged.
//  6 rst_i in cycle 10 of a restore -> cycle 11 outputs 0, busy_o=0; restart writes addr
//    1/2 first. FPU=1: 32 beats, last beat addr 63 on A only, done_o in cycle 34.

Source files
------------

// File: rtl/recovery_rf_restore_ctrl_if.sv
// Purpose : bus bundle between the restore controller, core writeback, RRF and core RF.
// Latency : n/a (wires only).
// Backpressure: core_ready throttles the restore write beats (rst_*).
// Ports   : core_* writeback in, rf_* RRF write/read, rst_* core RF restore writes,
//           core_ready from the core RF. master = controller, slave = surrounding logic.
interface recovery_rf_restore_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DataWidth  = 32
);
    logic                  core_we_a;
    logic                  core_we_b;
    logic [ADDR_WIDTH-1:0] core_waddr_a;
    logic [ADDR_WIDTH-1:0] core_waddr_b;
    logic [DataWidth-1:0]  core_wdata_a;
    logic [DataWidth-1:0]  core_wdata_b;

    logic                  rf_we_a;
    logic                  rf_we_b;
    logic [ADDR_WIDTH-1:0] rf_waddr_a;
    logic [ADDR_WIDTH-1:0] rf_waddr_b;
    logic [DataWidth-1:0]  rf_wdata_a;
    logic [DataWidth-1:0]  rf_wdata_b;
    logic [ADDR_WIDTH-1:0] rf_raddr_a;
    logic [ADDR_WIDTH-1:0] rf_raddr_b;
    logic [DataWidth-1:0]  rf_rdata_a;
    logic [DataWidth-1:0]  rf_rdata_b;

    logic                  rst_we_a;
    logic                  rst_we_b;
    logic [ADDR_WIDTH-1:0] rst_waddr_a;
    logic [ADDR_WIDTH-1:0] rst_waddr_b;
    logic [DataWidth-1:0]  rst_wdata_a;
    logic [DataWidth-1:0]  rst_wdata_b;
    logic                  core_ready;

    modport master (
        input  core_we_a, core_we_b, core_waddr_a, core_waddr_b, core_wdata_a, core_wdata_b,
        output rf_we_a, rf_we_b, rf_waddr_a, rf_waddr_b, rf_wdata_a, rf_wdata_b,
        output rf_raddr_a, rf_raddr_b,
        input  rf_rdata_a, rf_rdata_b,
        output rst_we_a, rst_we_b, rst_waddr_a, rst_waddr_b, rst_wdata_a, rst_wdata_b,
        input  core_ready
    );

    modport slave (
        output core_we_a, core_we_b, core_waddr_a, core_waddr_b, core_wdata_a, core_wdata_b,
        input  rf_we_a, rf_we_b, rf_waddr_a, rf_waddr_b, rf_wdata_a, rf_wdata_b,
        input  rf_raddr_a, rf_raddr_b,
        output rf_rdata_a, rf_rdata_b,
        input  rst_we_a, rst_we_b, rst_waddr_a, rst_waddr_b, rst_wdata_a, rst_wdata_b,
        output core_ready
    );
endinterface

// File: rtl/recovery_rf_restore_ctrl.sv
// Purpose : forwards core writebacks into the RRF; on start_i replays the RRF into the core RF.
// Latency : backup path combinational; first restore beat 2 cycles after start_i, then 1 beat/cycle.
// Backpressure: a restore beat is held stable until core_ready=1; backups blocked while busy.
// Ports   : clk_i/rst_i (sync, active-high), start_i, busy_o, done_o, backup_en_i, bus (master).
module recovery_rf_restore_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DataWidth  = 32,
    parameter bit FPU        = 1'b0,
    parameter bit PULP_ZFINX = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    input  logic backup_en_i,
    recovery_rf_restore_ctrl_if.master bus
);
    localparam int NumRegs = (FPU && !PULP_ZFINX) ? 64 : 32;
    // One extra bit so the counter can step past the last address without wrapping.
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cnt_b, cnt_n2;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  out_vld_q, out_vld_d;
    logic                  we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DataWidth-1:0]  wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

    assign cnt_b  = cnt_q + CW'(1);
    assign cnt_n2 = cnt_q + CW'(2);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        we_b_d    = we_b_q;
        waddr_a_d = waddr_a_q;
        waddr_b_d = waddr_b_q;
        wdata_a_d = wdata_a_q;
        wdata_b_d = wdata_b_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    cnt_d   = CW'(1);
                end
            end
            ISSUE: begin
                // A held beat is retired by the same ready that lets the next one load.
                if (!out_vld_q || bus.core_ready) begin
                    out_vld_d = 1'b1;
                    waddr_a_d = cnt_q[ADDR_WIDTH-1:0];
                    wdata_a_d = bus.rf_rdata_a;
                    we_b_d    = (cnt_b <= CW'(NumRegs - 1));
                    waddr_b_d = (cnt_b <= CW'(NumRegs - 1)) ? cnt_b[ADDR_WIDTH-1:0] : '0;
                    wdata_b_d = (cnt_b <= CW'(NumRegs - 1)) ? bus.rf_rdata_b : '0;
                    cnt_d     = cnt_n2;
                    if (cnt_n2 > CW'(NumRegs - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.core_ready) begin
                    out_vld_d = 1'b0;
                    we_b_d    = 1'b0;
                    waddr_a_d = '0;
                    waddr_b_d = '0;
                    wdata_a_d = '0;
                    wdata_b_d = '0;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CW'(1);
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= CW'(1);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_vld_q <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            waddr_b_q <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            out_vld_q <= out_vld_d;
            we_b_q    <= we_b_d;
            waddr_a_q <= waddr_a_d;
            waddr_b_q <= waddr_b_d;
            wdata_a_q <= wdata_a_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

    // Backup forwarding: a write in the start_i cycle still passes since busy rises a cycle later.
    assign bus.rf_we_a    = bus.core_we_a & backup_en_i & ~busy_q;
    assign bus.rf_we_b    = bus.core_we_b & backup_en_i & ~busy_q;
    assign bus.rf_waddr_a = bus.core_waddr_a;
    assign bus.rf_waddr_b = bus.core_waddr_b;
    assign bus.rf_wdata_a = bus.core_wdata_a;
    assign bus.rf_wdata_b = bus.core_wdata_b;

    assign bus.rf_raddr_a = (state_q == ISSUE) ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign bus.rf_raddr_b = (state_q == ISSUE) ? cnt_b[ADDR_WIDTH-1:0] : '0;

    assign bus.rst_we_a    = out_vld_q;
    assign bus.rst_we_b    = out_vld_q & we_b_q;
    assign bus.rst_waddr_a = waddr_a_q;
    assign bus.rst_waddr_b = waddr_b_q;
    assign bus.rst_wdata_a = wdata_a_q;
    assign bus.rst_wdata_b = wdata_b_q;
endmodule

// File: tb/tb_recovery_rf_restore_ctrl.sv
module tb_recovery_rf_restore_ctrl;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, start0, start1, ben0, ben1;
    logic busy0, busy1, done0, done1;

    recovery_rf_restore_ctrl_if #(.ADDR_WIDTH(AW), .DataWidth(DW)) b0 ();
    recovery_rf_restore_ctrl_if #(.ADDR_WIDTH(AW), .DataWidth(DW)) b1 ();

    recovery_rf_restore_ctrl #(.ADDR_WIDTH(AW), .DataWidth(DW), .FPU(1'b0), .PULP_ZFINX(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .start_i(start0), .busy_o(busy0), .done_o(done0),
        .backup_en_i(ben0), .bus(b0)
    );
    recovery_rf_restore_ctrl #(.ADDR_WIDTH(AW), .DataWidth(DW), .FPU(1'b1), .PULP_ZFINX(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .backup_en_i(ben1), .bus(b1)
    );

    // RRF contents: register r holds r*0x01010101.
    function automatic logic [31:0] pat(input logic [5:0] r);
        return {26'b0, r} * 32'h0101_0101;
    endfunction

    assign b0.rf_rdata_a = pat(b0.rf_raddr_a);
    assign b0.rf_rdata_b = pat(b0.rf_raddr_b);
    assign b1.rf_rdata_a = pat(b1.rf_raddr_a);
    assign b1.rf_rdata_b = pat(b1.rf_raddr_b);

    typedef struct {
        int          cyc;
        logic [5:0]  aa;
        logic [31:0] ad;
        logic        wb;
        logic [5:0]  ba;
        logic [31:0] bd;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    exp_done[2];
    int    done_seen[2];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    t0;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Expected beats of a full restore; beats due at or after stall_from slip by stall_len.
    task automatic push_restore(input int d, input int nregs, input int ts, input int stall_from,
                                input int stall_len);
        beat_t e;
        int    hc;
        hc = ts;
        for (int n = 0; n < nregs / 2; n++) begin
            hc   = ts + 2 + n;
            if (hc >= stall_from) hc += stall_len;
            e.cyc = hc;
            e.aa  = 6'(1 + 2 * n);
            e.ad  = pat(e.aa);
            e.wb  = (2 + 2 * n) <= (nregs - 1);
            e.ba  = 6'(2 + 2 * n);
            e.bd  = pat(e.ba);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        exp_done[d]  = hc + 1;
        done_seen[d] = 0;
    endtask

    task automatic mon_one(input int d, input logic we_a, input logic we_b, input logic [5:0] wa,
                           input logic [31:0] da, input logic [5:0] wbad, input logic [31:0] dbd,
                           input logic rdy, input logic dn);
        beat_t e;
        int    qs;
        qs = (d == 0) ? q0.size() : q1.size();
        if (dn) begin
            chk($sformatf("d%0d_done_cycle", d), 64'(cyc), 64'(exp_done[d]));
            done_seen[d]++;
        end
        if (we_a) begin
            if (qs == 0) begin
                chk($sformatf("d%0d_unexpected_beat_c%0d", d, cyc), 64'(we_a), 64'(0));
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("d%0d_addr_a_c%0d", d, cyc), 64'(wa), 64'(e.aa));
                chk($sformatf("d%0d_data_a_c%0d", d, cyc), 64'(da), 64'(e.ad));
                chk($sformatf("d%0d_we_b_c%0d", d, cyc), 64'(we_b), 64'(e.wb));
                if (e.wb) begin
                    chk($sformatf("d%0d_addr_b_c%0d", d, cyc), 64'(wbad), 64'(e.ba));
                    chk($sformatf("d%0d_data_b_c%0d", d, cyc), 64'(dbd), 64'(e.bd));
                end
                if (rdy) begin
                    chk($sformatf("d%0d_handshake_cycle", d), 64'(cyc), 64'(e.cyc));
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    endtask

    // Inputs for the current cycle are set before calling; sample, then advance one cycle.
    task automatic step();
        #1;
        mon_one(0, b0.rst_we_a, b0.rst_we_b, b0.rst_waddr_a, b0.rst_wdata_a, b0.rst_waddr_b,
                b0.rst_wdata_b, b0.core_ready, done0);
        mon_one(1, b1.rst_we_a, b1.rst_we_b, b1.rst_waddr_a, b1.rst_wdata_a, b1.rst_waddr_b,
                b1.rst_wdata_b, b1.core_ready, done1);
        @(negedge clk);
        cyc++;
    endtask

    task automatic end_check(input int d, input string tag);
        chk({tag, "_done_pulses"}, 64'(done_seen[d]), 64'(1));
        chk({tag, "_beats_left"}, 64'((d == 0) ? q0.size() : q1.size()), 64'(0));
        chk({tag, "_busy_after"}, 64'((d == 0) ? busy0 : busy1), 64'(0));
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0; ben0 = 1'b0; ben1 = 1'b0;
        b0.core_we_a = 1'b0; b0.core_we_b = 1'b0; b0.core_waddr_a = '0; b0.core_waddr_b = '0;
        b0.core_wdata_a = '0; b0.core_wdata_b = '0; b0.core_ready = 1'b1;
        b1.core_we_a = 1'b0; b1.core_we_b = 1'b0; b1.core_waddr_a = '0; b1.core_waddr_b = '0;
        b1.core_wdata_a = '0; b1.core_wdata_b = '0; b1.core_ready = 1'b1;
        exp_done[0] = -1; exp_done[1] = -1; done_seen[0] = 0; done_seen[1] = 0;
        @(negedge clk);
        step(); step();
        rst0 = 1'b0; rst1 = 1'b0;
        step();

        // Idle after reset
        #1;
        chk("rst_busy0", 64'(busy0), 64'(0));
        chk("rst_done0", 64'(done0), 64'(0));
        chk("rst_we_a0", 64'(b0.rst_we_a), 64'(0));
        chk("rst_we_b0", 64'(b0.rst_we_b), 64'(0));
        chk("rf_we_a0", 64'(b0.rf_we_a), 64'(0));
        chk("rf_we_b0", 64'(b0.rf_we_b), 64'(0));
        chk("rf_raddr_a0", 64'(b0.rf_raddr_a), 64'(0));
        chk("rst_busy1", 64'(busy1), 64'(0));
        chk("rst_we_a1", 64'(b1.rst_we_a), 64'(0));

        // Backup forwarding
        ben0 = 1'b1; b0.core_we_a = 1'b1; b0.core_waddr_a = 6'd5; b0.core_wdata_a = 32'hDEAD_BEEF;
        b0.core_we_b = 1'b1; b0.core_waddr_b = 6'd7; b0.core_wdata_b = 32'h1234_5678;
        #1;
        chk("bk_we_a", 64'(b0.rf_we_a), 64'(1));
        chk("bk_addr_a", 64'(b0.rf_waddr_a), 64'(5));
        chk("bk_data_a", 64'(b0.rf_wdata_a), 64'(32'hDEAD_BEEF));
        chk("bk_we_b", 64'(b0.rf_we_b), 64'(1));
        chk("bk_addr_b", 64'(b0.rf_waddr_b), 64'(7));
        chk("bk_data_b", 64'(b0.rf_wdata_b), 64'(32'h1234_5678));
        ben0 = 1'b0;
        #1;
        chk("bk_off_we_a", 64'(b0.rf_we_a), 64'(0));
        chk("bk_off_we_b", 64'(b0.rf_we_b), 64'(0));
        b0.core_we_b = 1'b0;
        step();

        // Full 32-register restore; a backup write in the start cycle still goes through
        t0 = cyc;
        start0 = 1'b1; ben0 = 1'b1; b0.core_we_a = 1'b1; b0.core_waddr_a = 6'd3;
        push_restore(0, 32, t0, NEVER, 0);
        #1;
        chk("start_cycle_backup", 64'(b0.rf_we_a), 64'(1));
        step();
        start0 = 1'b0; ben0 = 1'b0; b0.core_we_a = 1'b0;
        repeat (20) step();
        end_check(0, "r32");

        // Restore with core_ready low in relative cycles 5..7
        t0 = cyc;
        start0 = 1'b1;
        push_restore(0, 32, t0, t0 + 5, 3);
        step();
        start0 = 1'b0;
        for (int i = 1; i < 24; i++) begin
            b0.core_ready = !(i >= 5 && i <= 7);
            step();
        end
        b0.core_ready = 1'b1;
        end_check(0, "stall");

        // start_i and core writes while busy
        t0 = cyc;
        start0 = 1'b1;
        push_restore(0, 32, t0, NEVER, 0);
        step();
        start0 = 1'b0;
        repeat (5) step();
        start0 = 1'b1; ben0 = 1'b1; b0.core_we_a = 1'b1; b0.core_waddr_a = 6'd9;
        #1;
        chk("busy_blocks_backup", 64'(b0.rf_we_a), 64'(0));
        chk("busy_during", 64'(busy0), 64'(1));
        step();
        start0 = 1'b0; ben0 = 1'b0; b0.core_we_a = 1'b0;
        repeat (16) step();
        end_check(0, "busy_start");

        // Reset in relative cycle 10, then restart; FP-bank restore runs alongside
        t0 = cyc;
        start0 = 1'b1; start1 = 1'b1;
        push_restore(0, 32, t0, NEVER, 0);
        push_restore(1, 64, t0, NEVER, 0);
        step();
        start0 = 1'b0; start1 = 1'b0;
        repeat (9) step();
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        q0.delete();
        exp_done[0] = -1; done_seen[0] = 0;
        #1;
        chk("mid_rst_busy", 64'(busy0), 64'(0));
        chk("mid_rst_done", 64'(done0), 64'(0));
        chk("mid_rst_we_a", 64'(b0.rst_we_a), 64'(0));
        chk("mid_rst_we_b", 64'(b0.rst_we_b), 64'(0));
        chk("mid_rst_raddr", 64'(b0.rf_raddr_a), 64'(0));
        chk("fp_busy_unaffected", 64'(busy1), 64'(1));
        start0 = 1'b1;
        push_restore(0, 32, cyc, NEVER, 0);
        step();
        start0 = 1'b0;
        repeat (25) step();
        end_check(0, "restart");
        end_check(1, "fp64");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
